// File: rtl/verdict_collector.sv
// rtl/verdict_collector.sv - timestamped capture of two monitor streams into a record FIFO
//
// Purpose: every enabled cycle in which at least one monitor stream is active
// writes one record {timestamp, mask, out0, out1} into a DEPTH-deep FIFO that is
// drained through a valid/ready read port. Records that find the FIFO full are
// dropped and counted.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   en                            gates timestamp advance and capture
//   output_0/_aktv, output_1/_aktv monitor stream values and their valid bits
//   rec_valid/rec_ready           read-side handshake
//   rec_time/rec_mask/rec_out0/rec_out1  head record fields (0 while empty)
//   ovf, drop_cnt, clr_ovf        sticky overflow flag, saturating drop count, clear

module verdict_collector #(
    parameter int DW    = 64,
    parameter int TS_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] output_0,
    input  logic                 output_0_aktv,
    input  logic signed [DW-1:0] output_1,
    input  logic                 output_1_aktv,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [TS_W-1:0]      rec_time,
    output logic [1:0]           rec_mask,
    output logic signed [DW-1:0] rec_out0,
    output logic signed [DW-1:0] rec_out1,
    output logic                 ovf,
    output logic [7:0]           drop_cnt,
    input  logic                 clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts_q, ts_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic [TS_W-1:0] time_mem_q [DEPTH];
    logic [TS_W-1:0] time_mem_d [DEPTH];
    logic [1:0]      mask_mem_q [DEPTH];
    logic [1:0]      mask_mem_d [DEPTH];
    logic [DW-1:0]   out0_mem_q [DEPTH];
    logic [DW-1:0]   out0_mem_d [DEPTH];
    logic [DW-1:0]   out1_mem_q [DEPTH];
    logic [DW-1:0]   out1_mem_d [DEPTH];

    logic          empty, full, capture, pop, push, drop;
    logic [AW-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    // The extra pointer bit separates full from empty when the indices coincide.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    assign capture = en && (output_0_aktv || output_1_aktv);
    assign pop     = !empty && rec_ready;
    // A pop on the same edge frees the head slot, so a full FIFO still accepts.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        ts_d       = en ? ts_q + 1'b1 : ts_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        time_mem_d = time_mem_q;
        mask_mem_d = mask_mem_q;
        out0_mem_d = out0_mem_q;
        out1_mem_d = out1_mem_q;
        if (push) begin
            time_mem_d[wr_idx] = ts_q;
            mask_mem_d[wr_idx] = {output_1_aktv, output_0_aktv};
            out0_mem_d[wr_idx] = output_0_aktv ? output_0 : '0;
            out1_mem_d[wr_idx] = output_1_aktv ? output_1 : '0;
        end
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
        // A drop on the clearing edge wins: the cleared count restarts at one.
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = clr_ovf ? 8'd1
                       : (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                time_mem_q[i] <= '0;
                mask_mem_q[i] <= '0;
                out0_mem_q[i] <= '0;
                out1_mem_q[i] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            time_mem_q <= time_mem_d;
            mask_mem_q <= mask_mem_d;
            out0_mem_q <= out0_mem_d;
            out1_mem_q <= out1_mem_d;
        end
    end

    // Outputs come from registered state only; fields read as 0 while empty.
    assign rec_valid = !empty;
    assign rec_time  = empty ? '0 : time_mem_q[rd_idx];
    assign rec_mask  = empty ? '0 : mask_mem_q[rd_idx];
    assign rec_out0  = empty ? '0 : out0_mem_q[rd_idx];
    assign rec_out1  = empty ? '0 : out1_mem_q[rd_idx];
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_verdict_collector.sv
// tb/tb_verdict_collector.sv - self-checking bench for verdict_collector

module tb_verdict_collector;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic signed [63:0] output_0 = '0;
    logic               output_0_aktv = 1'b0;
    logic signed [63:0] output_1 = '0;
    logic               output_1_aktv = 1'b0;
    logic               rec_valid;
    logic               rec_ready = 1'b0;
    logic [31:0]        rec_time;
    logic [1:0]         rec_mask;
    logic signed [63:0] rec_out0;
    logic signed [63:0] rec_out1;
    logic               ovf;
    logic [7:0]         drop_cnt;
    logic               clr_ovf = 1'b0;

    verdict_collector #(.DW(64), .TS_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(output_0), .output_0_aktv(output_0_aktv),
        .output_1(output_1), .output_1_aktv(output_1_aktv),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_time(rec_time), .rec_mask(rec_mask),
        .rec_out0(rec_out0), .rec_out1(rec_out1),
        .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of records plus counters, stepped once per edge.
    typedef struct {
        logic [31:0] t;
        logic [1:0]  m;
        logic [63:0] o0;
        logic [63:0] o1;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_ts = 0;
    logic        m_ovf = 0;
    int          m_drop = 0;

    task automatic model_reset();
        mq.delete();
        m_ts   = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic model_edge();
        bit   can_pop, cap;
        rec_t r;
        can_pop = (mq.size() > 0) && rec_ready;
        cap     = en && (output_0_aktv || output_1_aktv);
        r.t  = m_ts;
        r.m  = {output_1_aktv, output_0_aktv};
        r.o0 = output_0_aktv ? output_0 : 64'd0;
        r.o1 = output_1_aktv ? output_1 : 64'd0;
        if (cap && mq.size() == DEPTH && !can_pop) begin
            m_ovf  = 1;
            m_drop = clr_ovf ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        end else begin
            if (clr_ovf) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (can_pop) void'(mq.pop_front());
            if (cap) mq.push_back(r);
        end
        if (en) m_ts = m_ts + 1;
    endtask

    task automatic model_check();
        bit v;
        v = mq.size() > 0;
        check("valid", rec_valid, v);
        check("time", rec_time, v ? mq[0].t : 32'd0);
        check("mask", rec_mask, v ? mq[0].m : 2'd0);
        check("out0", rec_out0, v ? mq[0].o0 : 64'd0);
        check("out1", rec_out1, v ? mq[0].o1 : 64'd0);
        check("ovf", ovf, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // Called at a negedge: drive, clock one edge, compare at the next negedge.
    task automatic step(input logic e, input logic a0, input logic signed [63:0] d0,
                        input logic a1, input logic signed [63:0] d1,
                        input logic rdy, input logic clr);
        en = e; output_0_aktv = a0; output_0 = d0;
        output_1_aktv = a1; output_1 = d1;
        rec_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic               en, v0, v1, rdy;
        logic signed [63:0] d0, d1;
        logic               e_valid;
        logic [31:0]        e_time;
        logic [1:0]         e_mask;
        logic signed [63:0] e_o0, e_o1;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic v0, input logic signed [63:0] d0,
                                input logic v1, input logic signed [63:0] d1, input logic rdy,
                                input logic ev, input logic [31:0] et, input logic [1:0] em,
                                input logic signed [63:0] eo0, input logic signed [63:0] eo1);
        vec_t x;
        x.en = e; x.v0 = v0; x.d0 = d0; x.v1 = v1; x.d1 = d1; x.rdy = rdy;
        x.e_valid = ev; x.e_time = et; x.e_mask = em; x.e_o0 = eo0; x.e_o1 = eo1;
        return x;
    endfunction

    vec_t tbl[7];

    initial begin
        // Expected outputs are those seen after the row's edge.
        tbl[0] = mk(1, 1,  5, 0,  0, 1,  1, 10, 2'b01,  5,  0);
        tbl[1] = mk(1, 0,  0, 0,  0, 1,  0,  0, 2'b00,  0,  0);
        tbl[2] = mk(1, 1, -3, 1,  7, 1,  1, 12, 2'b11, -3,  7);
        tbl[3] = mk(0, 1,  9, 0,  0, 0,  1, 12, 2'b11, -3,  7);
        tbl[4] = mk(0, 0,  0, 0,  0, 1,  0,  0, 2'b00,  0,  0);
        tbl[5] = mk(1, 0, 77, 1, -1, 0,  1, 13, 2'b10,  0, -1);
        tbl[6] = mk(1, 0,  0, 0,  0, 1,  0,  0, 2'b00,  0,  0);

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        model_check();
        rst = 1'b1;

        // Ten idle enabled cycles bring the timestamp to 10.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy, 0);
            check($sformatf("tbl%0d_valid", i), rec_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d_time", i), rec_time, tbl[i].e_time);
            check($sformatf("tbl%0d_mask", i), rec_mask, tbl[i].e_mask);
            check($sformatf("tbl%0d_out0", i), rec_out0, tbl[i].e_o0);
            check($sformatf("tbl%0d_out1", i), rec_out1, tbl[i].e_o1);
        end

        // Backpressure: 8 captures held, then drained in order.
        for (int i = 1; i <= 8; i++) step(1, 1, i, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            check("bp_order", rec_out0, i);
            step(1, 0, 0, 0, 0, 1, 0);
        end
        check("bp_empty", rec_valid, 0);

        // Overflow: 11 captures into 8 slots.
        for (int i = 1; i <= 11; i++) step(1, 1, 100 + i, 0, 0, 0, 0);
        check("ovf_set", ovf, 1);
        check("drop3", drop_cnt, 3);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", rec_out0, 100 + i);
            step(1, 0, 0, 0, 0, 1, 0);
        end
        check("ovf_drained", rec_valid, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("ovf_clr", ovf, 0);
        check("drop_clr", drop_cnt, 0);

        // Full FIFO with simultaneous capture and pop.
        for (int i = 1; i <= 8; i++) step(1, 1, 200 + i, 0, 0, 0, 0);
        step(1, 1, 999, 0, 0, 1, 0);
        check("fullpop_nodrop", ovf, 0);
        check("fullpop_occ", mq.size(), 8);
        for (int i = 2; i <= 8; i++) step(1, 0, 0, 0, 0, 1, 0);
        check("fullpop_last", rec_out0, 999);
        step(1, 0, 0, 0, 0, 1, 0);
        check("fullpop_empty", rec_valid, 0);

        // Saturation, then clear coinciding with a drop.
        for (int i = 0; i < 8; i++) step(1, 1, i, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) step(1, 0, 0, 1, i, 0, 0);
        check("drop_sat", drop_cnt, 255);
        step(1, 1, 1, 0, 0, 0, 1);
        check("clr_drop_ovf", ovf, 1);
        check("clr_drop_cnt", drop_cnt, 1);
        step(1, 0, 0, 0, 0, 1, 1);
        check("clr_only", drop_cnt, 0);
        repeat (8) step(1, 0, 0, 0, 0, 1, 0);

        // Reset mid-drain is immediate, then en gating.
        for (int i = 0; i < 4; i++) step(1, 1, 50 + i, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", rec_valid, 0);
        check("rst_time", rec_time, 0);
        check("rst_out0", rec_out0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 60 + i, 1, 1, 1, 0);
        check("en0_norec", rec_valid, 0);
        step(1, 1, 42, 0, 0, 0, 0);
        check("first_ts0", rec_time, 0);
        check("first_val", rec_out0, 42);
        step(1, 0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                 {$urandom, $urandom}, $urandom_range(0, 1), {$urandom, $urandom},
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
